// File: rtl/cpu_ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq_pkg
// Brief    : Shared types for the 8-bit CPU fetch/decode/execute sequencer:
//            opcodes, controller states, ALU operations, instruction fields.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_seq_pkg;

  // Instruction byte layout: [7:5] opcode, [4] bank select, [3:0] address
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int BANK_BIT = 4;
  localparam int ADDR_MSB = 3;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_ADD   = 3'b011,
    OP_SUB   = 3'b100,
    OP_JMP   = 3'b101,
    OP_JZ    = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_e;

  function automatic opcode_e opcode_of(input logic [7:0] instr);
    return opcode_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq_if
// Brief    : Bus bundle between the sequencer (master) and its environment:
//            instruction fetch, data handshake, decoder and ALU controls.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_ctrl_seq_if #(
  parameter int PC_W = 8
);
  logic            start_i;
  logic            imem_req_o;
  logic            imem_ack_i;
  logic [7:0]      imem_rdata_i;
  logic [PC_W-1:0] pc_o;
  logic [7:0]      instr_o;
  logic            rd_o;
  logic            wr_o;
  logic            mem_ack_i;
  logic            zero_i;
  logic [1:0]      alu_op_o;
  logic            acc_we_o;
  logic            halted_o;
  logic            fault_o;

  modport master (
    input  start_i, imem_ack_i, imem_rdata_i, mem_ack_i, zero_i,
    output imem_req_o, pc_o, instr_o, rd_o, wr_o, alu_op_o, acc_we_o,
           halted_o, fault_o
  );

  modport slave (
    output start_i, imem_ack_i, imem_rdata_i, mem_ack_i, zero_i,
    input  imem_req_o, pc_o, instr_o, rd_o, wr_o, alu_op_o, acc_we_o,
           halted_o, fault_o
  );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl_seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq_wait_timer
// Brief    : Handshake wait counter. expired is high during the WAIT_MAX-th
//            consecutive counted cycle, so an ack in that cycle still wins.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_seq_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  input  wire logic count_en,
  output logic      expired
);
  localparam logic [7:0] c_last = 8'(WAIT_MAX - 1);

  logic [7:0] r_cnt;

  // Count waiting cycles; saturate at the limit, restart on state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (count_en && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = count_en && (r_cnt == c_last);
endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq
// Brief    : Fetch/decode/execute sequencer for the 8-bit CPU. Fetches and
//            latches instruction bytes, drives decoder strobes and ALU
//            controls, and bounds every handshake with a wait timer.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_seq
  import cpu_ctrl_seq_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int WAIT_MAX = 15
) (
  input wire logic        clk,
  input wire logic        rst_n,
  cpu_ctrl_seq_if.master  bus
);
  ctrl_state_e     r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_instr;
  opcode_e         w_opc;
  logic            w_expired, w_wait_en, w_wait_clr;

  logic    r_req, r_rd, r_wr, r_acc_we, r_halted, r_fault;
  alu_op_e r_alu_op;
  logic    w_req_nxt, w_rd_nxt, w_wr_nxt, w_acc_we_nxt, w_halted_nxt, w_fault_nxt;
  alu_op_e w_alu_op_nxt;

  assign w_opc      = opcode_of(r_instr);
  assign w_wait_en  = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_wait_clr = (w_next != r_state);

  cpu_ctrl_seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_wait_clr),
    .count_en (w_wait_en),
    .expired  (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; an ack always beats the wait limit
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start_i) w_next = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ack_i)  w_next = ST_DECODE;
        else if (w_expired)  w_next = ST_FAULT;
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        case (w_opc)
          OP_LOAD, OP_STORE: w_next = ST_MEM;
          OP_HALT:           w_next = ST_HALT;
          default:           w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ack_i)   w_next = ST_FETCH;
        else if (w_expired)  w_next = ST_FAULT;
      end
      ST_HALT:   if (bus.start_i) w_next = ST_FETCH;
      ST_FAULT:  w_next = ST_FAULT;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so outputs come from flops
  always_comb begin
    w_req_nxt    = (w_next == ST_FETCH);
    w_rd_nxt     = (w_next == ST_MEM) && (w_opc == OP_LOAD);
    w_wr_nxt     = (w_next == ST_MEM) && (w_opc == OP_STORE);
    w_acc_we_nxt = 1'b0;
    w_alu_op_nxt = ALU_PASS;
    w_halted_nxt = (w_next == ST_HALT);
    w_fault_nxt  = (w_next == ST_FAULT);
    if (w_next == ST_EXEC) begin
      if (w_opc == OP_ADD) begin
        w_acc_we_nxt = 1'b1;
        w_alu_op_nxt = ALU_ADD;
      end else if (w_opc == OP_SUB) begin
        w_acc_we_nxt = 1'b1;
        w_alu_op_nxt = ALU_SUB;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req    <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_acc_we <= 1'b0;
      r_alu_op <= ALU_PASS;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_req    <= w_req_nxt;
      r_rd     <= w_rd_nxt;
      r_wr     <= w_wr_nxt;
      r_acc_we <= w_acc_we_nxt;
      r_alu_op <= w_alu_op_nxt;
      r_halted <= w_halted_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  // Program counter and instruction latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_instr <= '0;
    end else if ((r_state == ST_FETCH) && bus.imem_ack_i) begin
      r_instr <= bus.imem_rdata_i;
      r_pc    <= r_pc + PC_W'(1);
    end else if ((r_state == ST_EXEC) &&
                 ((w_opc == OP_JMP) || ((w_opc == OP_JZ) && bus.zero_i))) begin
      r_pc <= PC_W'({r_instr[BANK_BIT], r_instr[ADDR_MSB:0]});
    end
  end

  assign bus.imem_req_o = r_req;
  assign bus.pc_o       = r_pc;
  assign bus.instr_o    = r_instr;
  assign bus.rd_o       = r_rd;
  assign bus.wr_o       = r_wr;
  assign bus.alu_op_o   = r_alu_op;
  assign bus.halted_o   = r_halted;
  assign bus.fault_o    = r_fault;
  // Load data arrives with mem_ack, so its accumulator write must share that cycle
  assign bus.acc_we_o   = r_acc_we || ((r_state == ST_MEM) && r_rd && bus.mem_ack_i);
endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_seq
// Brief    : Self-checking bench for cpu_ctrl_seq with an instruction-level
//            reference model and randomized handshake delays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl_seq;
  localparam int WAIT_MAX = 15;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [7:0] m_pc;

  cpu_ctrl_seq_if #(.PC_W(8)) bus ();

  cpu_ctrl_seq #(.PC_W(8), .WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level expectations from the ISA rules and latency table
  task automatic model_instr(input logic [7:0] ins, input logic [7:0] pc, input bit z,
                             input int fwait, input int mwait, output logic [7:0] npc,
                             output int lat, output int rdc, output int wrc,
                             output int accn, output logic [1:0] accop);
    logic [2:0] op;
    op = ins[7:5];
    npc = pc + 8'd1; lat = fwait + 3; rdc = 0; wrc = 0; accn = 0; accop = 2'b11;
    case (op)
      3'd1: begin rdc = mwait + 1; lat = lat + mwait + 1; accn = 1; accop = 2'b00; end
      3'd2: begin wrc = mwait + 1; lat = lat + mwait + 1; end
      3'd3: begin accn = 1; accop = 2'b01; end
      3'd4: begin accn = 1; accop = 2'b10; end
      3'd5: npc = {3'b000, ins[4:0]};
      3'd6: if (z) npc = {3'b000, ins[4:0]};
      default: ;
    endcase
  endtask

  // Acts as instruction and data memory for one instruction, starting in a
  // cycle where the fetch request is visible. Returns when the next fetch,
  // HALT or FAULT is visible; measures what the DUT did along the way.
  task automatic run_instr(input logic [7:0] ins, input int fwait, input int mwait,
                           input bit z, output int lat, output int rdc, output int wrc,
                           output int accn, output logic [1:0] accop, output bit both,
                           output bit tmo);
    int sc;
    bit fetched;
    sc = 0; fetched = 0; lat = 0; rdc = 0; wrc = 0; accn = 0; accop = 2'b11;
    both = 0; tmo = 1;
    bus.zero_i = z;
    for (int c = 0; c < 200; c++) begin
      if (c > 0 && ((fetched && bus.imem_req_o) || bus.halted_o || bus.fault_o)) begin
        lat = c; tmo = 0;
        bus.imem_ack_i = 1'b0; bus.mem_ack_i = 1'b0;
        break;
      end
      if (!fetched && bus.imem_req_o && c == fwait) begin
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = ins; fetched = 1;
      end else begin
        bus.imem_ack_i = 1'b0; bus.imem_rdata_i = 8'($urandom);
      end
      if (bus.rd_o || bus.wr_o) begin
        if (bus.rd_o) rdc++;
        if (bus.wr_o) wrc++;
        if (bus.rd_o && bus.wr_o) both = 1;
        bus.mem_ack_i = (sc == mwait);
        sc++;
      end else begin
        bus.mem_ack_i = 1'b0;
      end
      #1;
      if (bus.acc_we_o) begin accn++; accop = bus.alu_op_o; end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start_i = 0; bus.imem_ack_i = 0; bus.imem_rdata_i = 0;
    bus.mem_ack_i = 0; bus.zero_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic kick(output bit tmo);
    tmo = 1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.imem_req_o) begin tmo = 0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [5:0] strobes;
    rst_n = 1'b0;
    bus.start_i = 0; bus.imem_ack_i = 0; bus.imem_rdata_i = 0;
    bus.mem_ack_i = 0; bus.zero_i = 0;
    #3;
    strobes = {bus.imem_req_o, bus.rd_o, bus.wr_o, bus.acc_we_o, bus.halted_o, bus.fault_o};
    n_checks++; if (strobes !== 6'b0) begin n_errors++; $display("FAIL reset_strobes: got %b expected 000000", strobes); end
    n_checks++; if (bus.pc_o !== 8'h00) begin n_errors++; $display("FAIL reset_pc: got %h expected 00", bus.pc_o); end
    n_checks++; if (bus.instr_o !== 8'h00) begin n_errors++; $display("FAIL reset_instr: got %h expected 00", bus.instr_o); end
    n_checks++; if (bus.alu_op_o !== 2'b00) begin n_errors++; $display("FAIL reset_alu_op: got %b expected 00", bus.alu_op_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_errors++; $display("FAIL idle_no_fetch: got %b expected 0", bus.imem_req_o); end
  endtask

  task automatic test_nop();
    bit tmo, both; int lat, rdc, wrc, accn; logic [1:0] accop;
    do_reset();
    kick(tmo);
    n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL start_fetch: got timeout=%b expected 0", tmo); end
    n_checks++; if (bus.pc_o !== 8'h00) begin n_errors++; $display("FAIL nop_pc0: got %h expected 00", bus.pc_o); end
    run_instr(8'h00, 0, 0, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL nop_latency: got %0d expected 3", lat); end
    n_checks++; if (bus.pc_o !== 8'h01) begin n_errors++; $display("FAIL nop_pc1: got %h expected 01", bus.pc_o); end
    n_checks++; if (accn !== 0 || rdc !== 0 || wrc !== 0) begin n_errors++; $display("FAIL nop_quiet: got acc=%0d rd=%0d wr=%0d expected 0 0 0", accn, rdc, wrc); end
    m_pc = 8'h01;
  endtask

  task automatic test_load();
    bit tmo, both; int lat, rdc, wrc, accn; logic [1:0] accop;
    run_instr(8'h23, 0, 2, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (rdc !== 3) begin n_errors++; $display("FAIL load_rd_cycles: got %0d expected 3", rdc); end
    n_checks++; if (wrc !== 0) begin n_errors++; $display("FAIL load_wr_cycles: got %0d expected 0", wrc); end
    n_checks++; if (bus.instr_o !== 8'h23) begin n_errors++; $display("FAIL load_instr: got %h expected 23", bus.instr_o); end
    n_checks++; if (accn !== 1 || accop !== 2'b00) begin n_errors++; $display("FAIL load_acc_we: got n=%0d op=%b expected n=1 op=00", accn, accop); end
    n_checks++; if (lat !== 6) begin n_errors++; $display("FAIL load_latency: got %0d expected 6", lat); end
    m_pc = 8'h02;
  endtask

  task automatic test_jz();
    bit tmo, both; int lat, rdc, wrc, accn; logic [1:0] accop;
    run_instr(8'hC5, 0, 0, 1, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.pc_o !== 8'h05) begin n_errors++; $display("FAIL jz_taken_pc: got %h expected 05", bus.pc_o); end
    run_instr(8'hC5, 0, 0, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.pc_o !== 8'h06) begin n_errors++; $display("FAIL jz_not_taken_pc: got %h expected 06", bus.pc_o); end
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL jz_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_random();
    bit tmo, both, z; int lat, rdc, wrc, accn, fw, mw;
    logic [1:0] accop, e_accop; logic [7:0] ins, e_npc; int e_lat, e_rdc, e_wrc, e_accn;
    do_reset();
    kick(tmo);
    n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL rand_start: got timeout=%b expected 0", tmo); end
    for (int i = 0; i < 40; i++) begin
      ins = {3'($urandom_range(0, 6)), 5'($urandom)};
      fw = $urandom_range(0, 3); mw = $urandom_range(0, 3); z = 1'($urandom_range(0, 1));
      model_instr(ins, m_pc, z, fw, mw, e_npc, e_lat, e_rdc, e_wrc, e_accn, e_accop);
      run_instr(ins, fw, mw, z, lat, rdc, wrc, accn, accop, both, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL rand_timeout[%0d]: got 1 expected 0 (ins %h)", i, ins); end
      n_checks++; if (lat !== e_lat) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d (ins %h)", i, lat, e_lat, ins); end
      n_checks++; if (bus.pc_o !== e_npc) begin n_errors++; $display("FAIL rand_pc[%0d]: got %h expected %h (ins %h)", i, bus.pc_o, e_npc, ins); end
      n_checks++; if (bus.instr_o !== ins) begin n_errors++; $display("FAIL rand_instr[%0d]: got %h expected %h", i, bus.instr_o, ins); end
      n_checks++; if (rdc !== e_rdc || wrc !== e_wrc || both) begin n_errors++; $display("FAIL rand_strobes[%0d]: got rd=%0d wr=%0d both=%b expected rd=%0d wr=%0d both=0", i, rdc, wrc, both, e_rdc, e_wrc); end
      n_checks++; if (accn !== e_accn || accop !== e_accop) begin n_errors++; $display("FAIL rand_acc[%0d]: got n=%0d op=%b expected n=%0d op=%b (ins %h)", i, accn, accop, e_accn, e_accop, ins); end
      m_pc = e_npc;
    end
  endtask

  task automatic test_boundary();
    bit tmo, both; int lat, rdc, wrc, accn; logic [1:0] accop;
    do_reset();
    kick(tmo);
    run_instr(8'h41, WAIT_MAX - 1, WAIT_MAX - 1, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.fault_o !== 1'b0 || bus.imem_req_o !== 1'b1) begin n_errors++; $display("FAIL limit_ack_store: got fault=%b req=%b expected 0 1", bus.fault_o, bus.imem_req_o); end
    n_checks++; if (lat !== 2 * WAIT_MAX + 2 || wrc !== WAIT_MAX) begin n_errors++; $display("FAIL limit_store_timing: got lat=%0d wr=%0d expected %0d %0d", lat, wrc, 2 * WAIT_MAX + 2, WAIT_MAX); end
    run_instr(8'h27, 0, WAIT_MAX - 1, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.fault_o !== 1'b0 || accn !== 1 || rdc !== WAIT_MAX) begin n_errors++; $display("FAIL limit_ack_load: got fault=%b acc=%0d rd=%0d expected 0 1 %0d", bus.fault_o, accn, rdc, WAIT_MAX); end
  endtask

  task automatic test_wrap_halt();
    bit tmo, both; int lat, rdc, wrc, accn; logic [1:0] accop;
    do_reset();
    kick(tmo);
    run_instr(8'hBF, 0, 0, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.pc_o !== 8'h1F) begin n_errors++; $display("FAIL jmp_pc: got %h expected 1f", bus.pc_o); end
    for (int i = 0; i < 224; i++) run_instr(8'h00, 0, 0, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.pc_o !== 8'hFF) begin n_errors++; $display("FAIL pc_ff: got %h expected ff", bus.pc_o); end
    run_instr(8'h00, 0, 0, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.pc_o !== 8'h00) begin n_errors++; $display("FAIL pc_wrap: got %h expected 00", bus.pc_o); end
    run_instr(8'h00, 0, 0, 0, lat, rdc, wrc, accn, accop, both, tmo);
    run_instr(8'hE0, 0, 0, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.halted_o !== 1'b1 || bus.imem_req_o !== 1'b0 || lat !== 3) begin n_errors++; $display("FAIL halt_enter: got halted=%b req=%b lat=%0d expected 1 0 3", bus.halted_o, bus.imem_req_o, lat); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.halted_o !== 1'b1 || bus.pc_o !== 8'h02) begin n_errors++; $display("FAIL halt_hold: got halted=%b pc=%h expected 1 02", bus.halted_o, bus.pc_o); end
    kick(tmo);
    n_checks++; if (tmo !== 1'b0 || bus.halted_o !== 1'b0 || bus.pc_o !== 8'h02) begin n_errors++; $display("FAIL halt_resume: got timeout=%b halted=%b pc=%h expected 0 0 02", tmo, bus.halted_o, bus.pc_o); end
  endtask

  task automatic test_fault();
    bit tmo, both; int lat, rdc, wrc, accn; logic [1:0] accop;
    do_reset();
    kick(tmo);
    run_instr(8'h41, 0, 1000, 0, lat, rdc, wrc, accn, accop, both, tmo);
    n_checks++; if (bus.fault_o !== 1'b1 || bus.wr_o !== 1'b0) begin n_errors++; $display("FAIL fault_enter: got fault=%b wr=%b expected 1 0", bus.fault_o, bus.wr_o); end
    n_checks++; if (wrc !== WAIT_MAX || lat !== WAIT_MAX + 3) begin n_errors++; $display("FAIL fault_timing: got wr=%0d lat=%0d expected %0d %0d", wrc, lat, WAIT_MAX, WAIT_MAX + 3); end
    bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (bus.fault_o !== 1'b1 || bus.imem_req_o !== 1'b0 || bus.wr_o !== 1'b0) begin n_errors++; $display("FAIL fault_sticky: got fault=%b req=%b wr=%b expected 1 0 0", bus.fault_o, bus.imem_req_o, bus.wr_o); end
    do_reset();
    n_checks++; if (bus.fault_o !== 1'b0) begin n_errors++; $display("FAIL fault_clear: got %b expected 0", bus.fault_o); end
  endtask

  task automatic test_async_reset();
    bit tmo, seen;
    do_reset();
    kick(tmo);
    seen = 0;
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 8'h41; bus.mem_ack_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.imem_ack_i = 1'b0;
      if (bus.wr_o) begin seen = 1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL store_wr_seen: got %b expected 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.wr_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.acc_we_o !== 1'b0) begin n_errors++; $display("FAIL async_strobes: got wr=%b req=%b acc=%b expected 0 0 0", bus.wr_o, bus.imem_req_o, bus.acc_we_o); end
    n_checks++; if (bus.pc_o !== 8'h00 || bus.instr_o !== 8'h00) begin n_errors++; $display("FAIL async_regs: got pc=%h instr=%h expected 00 00", bus.pc_o, bus.instr_o); end
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (bus.imem_req_o !== 1'b0 || bus.wr_o !== 1'b0) begin n_errors++; $display("FAIL async_idle: got req=%b wr=%b expected 0 0", bus.imem_req_o, bus.wr_o); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_pc = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_nop();
    test_load();
    test_jz();
    test_random();
    test_boundary();
    test_wrap_halt();
    test_fault();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
